// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a programmable terminal value,
// wrap or saturate at the boundary, parallel load and per-digit carry pulses.
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic [DIGITS-1:0]     digit_carry,
    output logic                  tc,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_q, count_d;
    logic [DIGITS-1:0] carry_q, carry_d;
    logic              tc_q, tc_d;
    logic              err_q, err_d;

    logic [W-1:0]      eff_limit;
    logic [W-1:0]      inc_val;
    logic [W-1:0]      dec_val;
    logic [DIGITS-1:0] all9;
    logic [DIGITS-1:0] all0;
    logic              ld_ok;
    logic              run9;
    logic              run0;

    // Ripple digit by digit; all9/all0 mark digits whose whole lower run rolls.
    always_comb begin
        eff_limit = '0;
        inc_val   = '0;
        dec_val   = '0;
        all9      = '0;
        all0      = '0;
        ld_ok     = 1'b1;
        run9      = 1'b1;
        run0      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (limit[4*i +: 4] > 4'd9)
                eff_limit[4*i +: 4] = 4'd9;
            else
                eff_limit[4*i +: 4] = limit[4*i +: 4];
            if (load_data[4*i +: 4] > 4'd9)
                ld_ok = 1'b0;

            if (!run9)
                inc_val[4*i +: 4] = count_q[4*i +: 4];
            else if (count_q[4*i +: 4] == 4'd9)
                inc_val[4*i +: 4] = 4'd0;
            else
                inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;

            if (!run0)
                dec_val[4*i +: 4] = count_q[4*i +: 4];
            else if (count_q[4*i +: 4] == 4'd0)
                dec_val[4*i +: 4] = 4'd9;
            else
                dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;

            run9    = run9 && (count_q[4*i +: 4] == 4'd9);
            run0    = run0 && (count_q[4*i +: 4] == 4'd0);
            all9[i] = run9;
            all0[i] = run0;
        end
    end

    // Valid BCD compares correctly as plain binary, so no digit-wise compare.
    always_comb begin
        count_d = count_q;
        carry_d = '0;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (!ld_ok)
                err_d = 1'b1;
            else if (load_data > eff_limit)
                count_d = eff_limit;
            else
                count_d = load_data;
        end else if (en) begin
            if (up_down) begin
                if (count_q >= eff_limit) begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        count_d = '0;
                        carry_d = all9;
                    end else begin
                        count_d = eff_limit;
                        if (count_q != eff_limit)
                            carry_d = all9;
                    end
                end else begin
                    count_d = inc_val;
                    carry_d = all9;
                end
            end else begin
                if (count_q > eff_limit) begin
                    count_d = eff_limit;
                end else if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        count_d = eff_limit;
                        carry_d = all0;
                    end
                end else begin
                    count_d = dec_val;
                    carry_d = all0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            carry_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count       = count_q;
    assign digit_carry = carry_q;
    assign tc          = tc_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: wrapping, saturating and
// three-digit instances driven by directed vectors.
`timescale 1ns/1ps
module tb_bcd_updown_counter;

    typedef struct {
        int          id;
        logic [11:0] cnt;
        logic [2:0]  car;
        logic        tc;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];

    logic        clk = 1'b0;
    logic        rst_s = 1'b0;
    logic        en_s = 1'b0;
    logic        ud_s = 1'b0;
    logic        ld_s = 1'b0;
    logic [11:0] ldd_s = '0;
    logic [11:0] lim_s = '0;
    int          sel = 0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    logic [7:0]  c0, c1;
    logic [11:0] c2;
    logic [1:0]  dc0, dc1;
    logic [2:0]  dc2;
    logic        tc0, tc1, tc2;
    logic        er0, er1, er2;

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(rst_s && sel == 0),
        .en(en_s && sel == 0), .up_down(ud_s),
        .load(ld_s && sel == 0), .load_data(ldd_s[7:0]),
        .limit(lim_s[7:0]), .count(c0), .digit_carry(dc0),
        .tc(tc0), .load_err(er0)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(rst_s && sel == 1),
        .en(en_s && sel == 1), .up_down(ud_s),
        .load(ld_s && sel == 1), .load_data(ldd_s[7:0]),
        .limit(lim_s[7:0]), .count(c1), .digit_carry(dc1),
        .tc(tc1), .load_err(er1)
    );

    bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) u_three (
        .clk(clk), .reset(rst_s && sel == 2),
        .en(en_s && sel == 2), .up_down(ud_s),
        .load(ld_s && sel == 2), .load_data(ldd_s),
        .limit(lim_s), .count(c2), .digit_carry(dc2),
        .tc(tc2), .load_err(er2)
    );

    function automatic logic [11:0] bcd(input int n);
        logic [11:0] r;
        r[3:0]  = 4'((n % 10));
        r[7:4]  = 4'(((n / 10) % 10));
        r[11:8] = 4'(((n / 100) % 10));
        return r;
    endfunction

    // rst, load, en, up_down, load_data, limit -> expected next cycle
    task automatic drive(
        input int          id,
        input bit          r,
        input bit          l,
        input bit          e,
        input bit          ud,
        input logic [11:0] ldd,
        input logic [11:0] lim,
        input logic [11:0] ec,
        input logic [2:0]  eca,
        input bit          et,
        input bit          ee,
        input string       nm
    );
        exp_t x;
        @(negedge clk);
        sel   = id;
        rst_s = r;
        ld_s  = l;
        en_s  = e;
        ud_s  = ud;
        ldd_s = ldd;
        lim_s = lim;
        x.id   = id;
        x.cnt  = ec;
        x.car  = eca;
        x.tc   = et;
        x.err  = ee;
        x.name = nm;
        q.push_back(x);
    endtask

    // Monitor: every cycle the counters present registered outputs
    always @(posedge clk) begin
        exp_t        x;
        logic [11:0] ac;
        logic [2:0]  aca;
        logic        at, ae;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            ac = '0; aca = '0; at = 1'b0; ae = 1'b0;
            case (x.id)
                0: begin
                    ac = {4'h0, c0}; aca = {1'b0, dc0};
                    at = tc0; ae = er0;
                end
                1: begin
                    ac = {4'h0, c1}; aca = {1'b0, dc1};
                    at = tc1; ae = er1;
                end
                default: begin
                    ac = c2; aca = dc2; at = tc2; ae = er2;
                end
            endcase
            vectors++;
            if (ac !== x.cnt || aca !== x.car ||
                at !== x.tc || ae !== x.err) begin
                miscompares++;
                $display("FAIL %s: got cnt=%h car=%b tc=%b err=%b, want cnt=%h car=%b tc=%b err=%b",
                         x.name, ac, aca, at, ae,
                         x.cnt, x.car, x.tc, x.err);
            end
        end
    end

    initial begin
        int n;
        // Wrapping counter, full 00..99 sweep
        drive(0, 1, 1, 1, 1, 12'h055, 12'h099, 12'h000, 3'b000, 0, 0, "reset0");
        for (int v = 0; v < 100; v++) begin
            n = (v + 1) % 100;
            drive(0, 0, 0, 1, 1, 12'h000, 12'h099, bcd(n),
                  {1'b0, v == 99, (v % 10) == 9}, v == 99, 0, "up_sweep");
        end
        // Down from 00 with limit 59
        drive(0, 0, 0, 1, 0, 12'h000, 12'h059, 12'h059, 3'b011, 1, 0, "down_wrap");
        for (int v = 58; v >= 49; v--) begin
            drive(0, 0, 0, 1, 0, 12'h000, 12'h059, bcd(v),
                  {2'b00, v == 49}, 0, 0, "down_run");
        end
        // Limit digit above 9 behaves as 9
        drive(0, 0, 1, 0, 1, 12'h058, 12'h05F, 12'h058, 3'b000, 0, 0, "ld58");
        drive(0, 0, 0, 1, 1, 12'h000, 12'h05F, 12'h059, 3'b000, 0, 0, "up_lim5F");
        drive(0, 0, 0, 1, 1, 12'h000, 12'h05F, 12'h000, 3'b001, 1, 0, "wrap_lim5F");
        // Loads, invalid load, clamped load
        drive(0, 0, 1, 1, 1, 12'h047, 12'h099, 12'h047, 3'b000, 0, 0, "ld47");
        drive(0, 0, 1, 1, 1, 12'h03A, 12'h099, 12'h047, 3'b000, 0, 1, "ld3A_err");
        drive(0, 0, 0, 0, 1, 12'h03A, 12'h099, 12'h047, 3'b000, 0, 0, "idle_hold");
        drive(0, 0, 1, 0, 1, 12'h080, 12'h065, 12'h065, 3'b000, 0, 0, "ld80_clamp");
        // Limit lowered below count
        drive(0, 0, 1, 0, 1, 12'h037, 12'h099, 12'h037, 3'b000, 0, 0, "ld37");
        drive(0, 0, 0, 1, 0, 12'h000, 12'h020, 12'h020, 3'b000, 0, 0, "dn_clamp20");
        drive(0, 0, 0, 1, 1, 12'h000, 12'h020, 12'h000, 3'b000, 1, 0, "up_wrap20");
        // Reset beats load and en
        drive(0, 0, 1, 0, 1, 12'h042, 12'h099, 12'h042, 3'b000, 0, 0, "ld42");
        drive(0, 1, 1, 1, 1, 12'h011, 12'h099, 12'h000, 3'b000, 0, 0, "rst_ld_en");
        drive(0, 0, 0, 0, 1, 12'h000, 12'h099, 12'h000, 3'b000, 0, 0, "post_rst");
        drive(0, 0, 0, 1, 1, 12'h000, 12'h099, 12'h001, 3'b000, 0, 0, "resume");

        // Saturating counter
        drive(1, 1, 0, 0, 1, 12'h000, 12'h023, 12'h000, 3'b000, 0, 0, "reset1");
        drive(1, 0, 1, 0, 1, 12'h021, 12'h023, 12'h021, 3'b000, 0, 0, "ld21");
        drive(1, 0, 0, 1, 1, 12'h000, 12'h023, 12'h022, 3'b000, 0, 0, "sat_22");
        drive(1, 0, 0, 1, 1, 12'h000, 12'h023, 12'h023, 3'b000, 0, 0, "sat_23");
        drive(1, 0, 0, 1, 1, 12'h000, 12'h023, 12'h023, 3'b000, 1, 0, "sat_hold1");
        drive(1, 0, 0, 1, 1, 12'h000, 12'h023, 12'h023, 3'b000, 1, 0, "sat_hold2");
        drive(1, 0, 0, 1, 1, 12'h000, 12'h023, 12'h023, 3'b000, 1, 0, "sat_hold3");
        drive(1, 0, 1, 0, 0, 12'h010, 12'h023, 12'h010, 3'b000, 0, 0, "ld10");
        drive(1, 0, 0, 1, 0, 12'h000, 12'h023, 12'h009, 3'b001, 0, 0, "dn_10_09");
        drive(1, 0, 1, 0, 0, 12'h000, 12'h023, 12'h000, 3'b000, 0, 0, "ld00");
        drive(1, 0, 0, 1, 0, 12'h000, 12'h023, 12'h000, 3'b000, 1, 0, "sat_zero");

        // Three digits
        drive(2, 1, 0, 0, 1, 12'h000, 12'h999, 12'h000, 3'b000, 0, 0, "reset2");
        drive(2, 0, 1, 0, 1, 12'h999, 12'h999, 12'h999, 3'b000, 0, 0, "ld999");
        drive(2, 0, 0, 1, 1, 12'h000, 12'h999, 12'h000, 3'b111, 1, 0, "wrap999");
        drive(2, 0, 0, 1, 0, 12'h000, 12'h999, 12'h999, 3'b111, 1, 0, "dwrap000");
        drive(2, 0, 0, 1, 0, 12'h000, 12'h999, 12'h998, 3'b000, 0, 0, "dn998");
        drive(2, 0, 0, 0, 0, 12'h000, 12'h999, 12'h998, 3'b000, 0, 0, "idle3");

        @(negedge clk);
        en_s = 1'b0;
        ld_s = 1'b0;
        rst_s = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
